// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the decode/execute issue controller: FSM state
// encodings and the default number of instructions allowed in flight.
package pipe_ctrl_pkg;

    localparam int PIPE_DEPTH = 4;

    typedef enum logic [1:0] {
        PIPE_ST_RUN   = 2'd0,
        PIPE_ST_DRAIN = 2'd1,
        PIPE_ST_REQ   = 2'd2,
        PIPE_ST_DONE  = 2'd3
    } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_gpr_scoreboard.sv
// Per-GPR count of in-flight writes (x1..x31) with two read-port hazard lookups.
// x0 has no counter, so it never reports a pending write.
module gpr_scoreboard #(
    parameter int CW = 3
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       inc_en,
    input  logic [4:0] inc_rd,
    input  logic       dec_en,
    input  logic [4:0] dec_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       hazard1,
    output logic       hazard2
);

    logic [31:0] pend_nz;

    assign pend_nz[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pend
            logic [CW-1:0] pend_reg;
            logic          inc_hit;
            logic          dec_hit;

            assign inc_hit = inc_en && (inc_rd == 5'(gi));
            assign dec_hit = dec_en && (dec_rd == 5'(gi));

            // Count pending writes; simultaneous issue and retire cancel, and a
            // decrement of an empty counter is dropped (saturate at zero).
            always_ff @(posedge clk) begin
                if (srst) begin
                    pend_reg <= '0;
                end else if (inc_hit && !dec_hit) begin
                    pend_reg <= pend_reg + CW'(1);
                end else if (dec_hit && !inc_hit && (pend_reg != '0)) begin
                    pend_reg <= pend_reg - CW'(1);
                end
            end

            // Flag a retire of a register that has no write outstanding.
            always_ff @(posedge clk) begin
                if (!srst && dec_hit && !inc_hit) begin
                    assert (pend_reg != '0)
                    else $error("gpr_scoreboard: retire of x%0d with no pending write", gi);
                end
            end

            assign pend_nz[gi] = (pend_reg != '0);
        end
    endgenerate

    assign hazard1 = pend_nz[rs1];
    assign hazard2 = pend_nz[rs2];

endmodule

// File: rtl/pipe_ctrl.sv
// Issue controller between decode and execute: RAW stall via the GPR
// scoreboard, in-flight limit, redirect flush, and fence.i sequencing
// (drain, I-cache invalidate handshake, single-cycle issue plus refetch).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_valid_i,
    input  logic [4:0] dec_rs1_i,
    input  logic [4:0] dec_rs2_i,
    input  logic [4:0] dec_rd_i,
    input  logic       dec_gr_we_i,
    input  logic       dec_fence_i_i,
    output logic       dec_ready_o,
    input  logic       exu_redirect_i,
    input  logic       wb_valid_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_gr_we_i,
    output logic       flush_o,
    output logic       icache_flush_req_o,
    input  logic       icache_flush_ack_i,
    output logic       fence_redirect_o,
    output logic       busy_o
);

    pipe_state_t   state_reg;
    pipe_state_t   state_next;
    logic [CW-1:0] inflight_reg;
    logic          hazard1;
    logic          hazard2;
    logic          hazard;
    logic          ready_next;
    logic          issue;
    logic          retire_ok;

    gpr_scoreboard #(
        .CW(CW)
    ) u_scoreboard (
        .clk     (clock),
        .srst    (reset),
        .inc_en  (issue && dec_gr_we_i && (dec_rd_i != 5'd0)),
        .inc_rd  (dec_rd_i),
        .dec_en  (wb_valid_i && wb_gr_we_i && (wb_rd_i != 5'd0)),
        .dec_rd  (wb_rd_i),
        .rs1     (dec_rs1_i),
        .rs2     (dec_rs2_i),
        .hazard1 (hazard1),
        .hazard2 (hazard2)
    );

    assign hazard    = hazard1 | hazard2;
    assign issue     = dec_valid_i & dec_ready_o;
    assign retire_ok = wb_valid_i & (inflight_reg != '0);

    // Next state and issue permission; redirect kills a speculative fence.i in DRAIN.
    always_comb begin
        state_next = state_reg;
        ready_next = 1'b0;
        case (state_reg)
            PIPE_ST_RUN: begin
                ready_next = dec_valid_i & !hazard & (inflight_reg != CW'(DEPTH))
                           & !exu_redirect_i & !dec_fence_i_i;
                if (dec_valid_i && dec_fence_i_i && !exu_redirect_i) begin
                    state_next = PIPE_ST_DRAIN;
                end
            end
            PIPE_ST_DRAIN: begin
                if (exu_redirect_i) begin
                    state_next = PIPE_ST_RUN;
                end else if (inflight_reg == '0) begin
                    state_next = PIPE_ST_REQ;
                end
            end
            PIPE_ST_REQ: begin
                if (icache_flush_ack_i) begin
                    state_next = PIPE_ST_DONE;
                end
            end
            PIPE_ST_DONE: begin
                ready_next = 1'b1;
                state_next = PIPE_ST_RUN;
            end
            default: begin
                state_next = PIPE_ST_RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= PIPE_ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // In-flight counter: issue increments, retire decrements, both together hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_reg <= '0;
        end else if (issue && !retire_ok) begin
            inflight_reg <= inflight_reg + CW'(1);
        end else if (retire_ok && !issue) begin
            inflight_reg <= inflight_reg - CW'(1);
        end
    end

    // Flag a retire arriving when nothing is in flight.
    always_ff @(posedge clock) begin
        if (!reset && wb_valid_i) begin
            assert (inflight_reg != '0)
            else $error("pipe_ctrl: retire with nothing in flight");
        end
    end

    assign dec_ready_o        = ready_next & !reset;
    assign flush_o            = exu_redirect_i & !reset;
    assign icache_flush_req_o = (state_reg == PIPE_ST_REQ);
    assign fence_redirect_o   = (state_reg == PIPE_ST_DONE);
    assign busy_o             = (inflight_reg != '0) || (state_reg != PIPE_ST_RUN);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: RAW stalls, x0, full pipe, redirect, fence.i
// (normal, minimum-latency, aborted, reset mid-sequence).
module tb_pipe_ctrl;

    logic       clock;
    logic       reset;
    logic       dec_valid_i;
    logic [4:0] dec_rs1_i;
    logic [4:0] dec_rs2_i;
    logic [4:0] dec_rd_i;
    logic       dec_gr_we_i;
    logic       dec_fence_i_i;
    logic       dec_ready_o;
    logic       exu_redirect_i;
    logic       wb_valid_i;
    logic [4:0] wb_rd_i;
    logic       wb_gr_we_i;
    logic       flush_o;
    logic       icache_flush_req_o;
    logic       icache_flush_ack_i;
    logic       fence_redirect_o;
    logic       busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .dec_valid_i        (dec_valid_i),
        .dec_rs1_i          (dec_rs1_i),
        .dec_rs2_i          (dec_rs2_i),
        .dec_rd_i           (dec_rd_i),
        .dec_gr_we_i        (dec_gr_we_i),
        .dec_fence_i_i      (dec_fence_i_i),
        .dec_ready_o        (dec_ready_o),
        .exu_redirect_i     (exu_redirect_i),
        .wb_valid_i         (wb_valid_i),
        .wb_rd_i            (wb_rd_i),
        .wb_gr_we_i         (wb_gr_we_i),
        .flush_o            (flush_o),
        .icache_flush_req_o (icache_flush_req_o),
        .icache_flush_ack_i (icache_flush_ack_i),
        .fence_redirect_o   (fence_redirect_o),
        .busy_o             (busy_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-28s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-28s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Settle combinational outputs mid-cycle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic idle();
        dec_valid_i        = 1'b0;
        dec_rs1_i          = 5'd0;
        dec_rs2_i          = 5'd0;
        dec_rd_i           = 5'd0;
        dec_gr_we_i        = 1'b0;
        dec_fence_i_i      = 1'b0;
        exu_redirect_i     = 1'b0;
        wb_valid_i         = 1'b0;
        wb_rd_i            = 5'd0;
        wb_gr_we_i         = 1'b0;
        icache_flush_ack_i = 1'b0;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic we, input logic fence);
        dec_valid_i   = 1'b1;
        dec_rs1_i     = rs1;
        dec_rs2_i     = rs2;
        dec_rd_i      = rd;
        dec_gr_we_i   = we;
        dec_fence_i_i = fence;
    endtask

    task automatic retire(input logic [4:0] rd, input logic we);
        wb_valid_i = 1'b1;
        wb_rd_i    = rd;
        wb_gr_we_i = we;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        // Reset: even with decode and redirect active, every output stays low.
        present(5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
        exu_redirect_i = 1'b1;
        tick();
        tick();
        settle();
        check("rst_ready",      dec_ready_o,        0);
        check("rst_flush",      flush_o,            0);
        check("rst_icreq",      icache_flush_req_o, 0);
        check("rst_fredir",     fence_redirect_o,   0);
        check("rst_busy",       busy_o,             0);
        idle();
        reset = 1'b0;
        tick();

        // RAW on rs1: x5 writer, then reader stalls until the cycle after retire.
        idle(); present(5'd1, 5'd2, 5'd5, 1'b1, 1'b0); settle();
        check("raw_writer_ready", dec_ready_o, 1);
        tick();
        idle(); present(5'd5, 5'd0, 5'd6, 1'b1, 1'b0); settle();
        check("raw_stall", dec_ready_o, 0);
        check("raw_busy",  busy_o,      1);
        tick();
        idle(); present(5'd5, 5'd0, 5'd6, 1'b1, 1'b0); retire(5'd5, 1'b1); settle();
        check("raw_no_bypass", dec_ready_o, 0);
        tick();
        idle(); present(5'd5, 5'd0, 5'd6, 1'b1, 1'b0); settle();
        check("raw_release", dec_ready_o, 1);
        tick();
        idle(); retire(5'd6, 1'b1); tick();

        // RAW on rs2.
        idle(); present(5'd0, 5'd0, 5'd7, 1'b1, 1'b0); settle();
        check("rs2_writer_ready", dec_ready_o, 1);
        tick();
        idle(); present(5'd0, 5'd7, 5'd0, 1'b0, 1'b0); settle();
        check("rs2_stall", dec_ready_o, 0);
        dec_valid_i = 1'b0;
        retire(5'd7, 1'b1);
        tick();
        idle(); settle();
        check("rs2_idle_busy", busy_o, 0);

        // x0 writer then x0 reader: never a stall.
        idle(); present(5'd0, 5'd0, 5'd0, 1'b1, 1'b0); settle();
        check("x0_writer_ready", dec_ready_o, 1);
        tick();
        idle(); present(5'd0, 5'd0, 5'd0, 1'b1, 1'b0); settle();
        check("x0_reader_ready", dec_ready_o, 1);
        tick();
        idle(); retire(5'd0, 1'b1); tick();
        idle(); retire(5'd0, 1'b1); tick();
        idle(); settle();
        check("x0_idle_busy", busy_o, 0);

        // Full: 4 independent issues, 5th stalls; retire in N frees issue in N+1.
        for (int i = 0; i < 4; i++) begin
            idle(); present(5'd0, 5'd0, 5'(10 + i), 1'b1, 1'b0); settle();
            check($sformatf("full_issue%0d", i), dec_ready_o, 1);
            tick();
        end
        idle(); present(5'd0, 5'd0, 5'd14, 1'b1, 1'b0); settle();
        check("full_5th_stall", dec_ready_o, 0);
        retire(5'd10, 1'b1); settle();
        check("full_retire_same_cycle", dec_ready_o, 0);
        tick();
        idle(); present(5'd0, 5'd0, 5'd14, 1'b1, 1'b0); settle();
        check("full_next_cycle_ready", dec_ready_o, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(); retire(5'(11 + i), 1'b1); tick();
        end
        idle(); settle();
        check("full_drained_busy", busy_o, 0);

        // Redirect: flush same cycle, no issue; killed instructions clean the scoreboard.
        idle(); present(5'd0, 5'd0, 5'd20, 1'b1, 1'b0); tick();
        idle(); present(5'd0, 5'd0, 5'd21, 1'b1, 1'b0); tick();
        idle(); present(5'd0, 5'd0, 5'd22, 1'b1, 1'b0); exu_redirect_i = 1'b1; settle();
        check("redir_flush", flush_o,     1);
        check("redir_ready", dec_ready_o, 0);
        tick();
        idle(); settle();
        check("redir_flush_drop", flush_o, 0);
        retire(5'd20, 1'b1); tick();
        idle(); retire(5'd21, 1'b1); tick();
        idle(); settle();
        check("redir_clean_busy", busy_o, 0);
        present(5'd20, 5'd21, 5'd0, 1'b0, 1'b0); settle();
        check("redir_clean_pend", dec_ready_o, 1);
        dec_valid_i = 1'b0;
        tick();

        // fence.i with 2 in flight, ack 3 cycles after req.
        idle(); present(5'd0, 5'd0, 5'd1, 1'b1, 1'b0); tick();
        idle(); present(5'd0, 5'd0, 5'd2, 1'b1, 1'b0); tick();
        idle(); present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1); settle();
        check("fence_run_ready", dec_ready_o, 0);
        tick();
        idle(); present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1); retire(5'd1, 1'b1); settle();
        check("fence_drain1_ready", dec_ready_o, 0);
        check("fence_drain1_req",   icache_flush_req_o, 0);
        tick();
        idle(); present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1); retire(5'd2, 1'b1); settle();
        check("fence_drain2_req", icache_flush_req_o, 0);
        tick();
        idle(); present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1); settle();
        check("fence_drain3_req",   icache_flush_req_o, 0);
        check("fence_drain3_ready", dec_ready_o, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(); present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
            icache_flush_ack_i = (i == 3);
            settle();
            check($sformatf("fence_req_c%0d", i), icache_flush_req_o, 1);
            check($sformatf("fence_req_ready%0d", i), dec_ready_o, 0);
            tick();
        end
        idle(); present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1); settle();
        check("fence_done_req",    icache_flush_req_o, 0);
        check("fence_done_ready",  dec_ready_o,        1);
        check("fence_done_fredir", fence_redirect_o,   1);
        tick();
        idle(); settle();
        check("fence_back_fredir", fence_redirect_o, 0);
        check("fence_back_busy",   busy_o,           1);
        retire(5'd0, 1'b0); tick();
        idle(); settle();
        check("fence_end_busy", busy_o, 0);

        // Minimum fence.i: empty pipe, immediate ack, issues on the 4th cycle.
        idle(); present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1); tick();
        settle();
        check("minf_drain_ready", dec_ready_o, 0);
        tick();
        icache_flush_ack_i = 1'b1; settle();
        check("minf_req", icache_flush_req_o, 1);
        tick();
        icache_flush_ack_i = 1'b0; settle();
        check("minf_done_ready",  dec_ready_o,      1);
        check("minf_done_fredir", fence_redirect_o, 1);
        tick();
        idle(); retire(5'd0, 1'b0); tick();
        idle();

        // Aborted fence.i: redirect during DRAIN returns to RUN, no I-cache request.
        present(5'd0, 5'd0, 5'd3, 1'b1, 1'b0); tick();
        idle(); present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1); tick();
        exu_redirect_i = 1'b1; settle();
        check("abort_flush", flush_o,     1);
        check("abort_ready", dec_ready_o, 0);
        tick();
        idle(); settle();
        check("abort_req0", icache_flush_req_o, 0);
        present(5'd0, 5'd0, 5'd0, 1'b0, 1'b0); settle();
        check("abort_run_ready", dec_ready_o, 1);
        dec_valid_i = 1'b0;
        retire(5'd3, 1'b1); tick();
        idle(); settle();
        check("abort_req1", icache_flush_req_o, 0);
        check("abort_busy", busy_o,             0);

        // Reset asserted while the I-cache request is pending.
        present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1); tick();
        tick();
        settle();
        check("rstmid_req_before", icache_flush_req_o, 1);
        reset = 1'b1; settle();
        check("rstmid_ready_in_reset", dec_ready_o, 0);
        tick();
        settle();
        check("rstmid_req_after", icache_flush_req_o, 0);
        check("rstmid_busy",      busy_o,             0);
        idle();
        reset = 1'b0;
        tick();
        present(5'd0, 5'd0, 5'd0, 1'b0, 1'b0); settle();
        check("rstmid_run_ready", dec_ready_o, 1);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
